// File: rtl/sram_port_arbiter.sv
// Shares one single-ported, fixed-latency SRAM between the fetch stage and the memory stage.
// Optional macro FETCH_REUSE_EN adds a one-entry fetch buffer that skips the SRAM on a tag hit.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SRAM_LAT   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              owner
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate and latch the winner's request
  // ACCESS | sram_cs held for SRAM_LAT cycles on the latched request
  // DONE   | one-cycle ready pulse to the owner; requests ignored
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int             SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]     CNT_LAST   = 4'(SRAM_LAT - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant;
  logic              fetch_win;

  assign grant      = if_req | mem_req;
  assign fetch_win  = if_req & (~mem_req | (starve_cnt >= STARVE_LIM));
  assign sram_addr  = lat_addr;
  assign sram_wdata = lat_wdata;

`ifdef FETCH_REUSE_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag;
  logic [DATA_W-1:0] buf_data;
  logic              buf_hit;

  assign buf_hit = buf_valid && (buf_tag == if_addr);

  // Fill on every completed SRAM fetch; drop on a granted store to the buffered address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == ACCESS && cnt == CNT_LAST && !owner) begin
      buf_valid <= 1'b1;
      buf_tag   <= lat_addr;
      buf_data  <= sram_rdata;
    end else if (state == IDLE && grant && !fetch_win && mem_we && mem_addr == buf_tag) begin
      buf_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            busy  <= 1'b1;
            owner <= ~fetch_win;
            if (fetch_win) begin
              starve_cnt <= '0;
              lat_addr   <= if_addr;
`ifdef FETCH_REUSE_EN
              if (buf_hit) begin
                state    <= DONE;
                if_ready <= 1'b1;
                if_rdata <= buf_data;
              end else
`endif
              begin
                state   <= ACCESS;
                cnt     <= '0;
                sram_cs <= 1'b1;
                sram_we <= 1'b0;
              end
            end else begin
              // Only a grant taken while fetch waits counts toward starvation.
              if (if_req && starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
              lat_addr  <= mem_addr;
              lat_wdata <= mem_wdata;
              state     <= ACCESS;
              cnt       <= '0;
              sram_cs   <= 1'b1;
              sram_we   <= mem_we;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            sram_cs <= 1'b0;
            sram_we <= 1'b0;
            if (owner) begin
              mem_ready <= 1'b1;
              if (!sram_we) mem_rdata <= sram_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= sram_rdata;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model (arbitration order, latency, data, buffer).
module tb_sram_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 4;
  localparam int SMAX = 8;
`ifdef FETCH_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          busy;
  logic          owner;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sram_mem [256];
  logic [DW-1:0] ref_mem  [256];

  // reference model state
  int            m_starve;
  bit            m_bv;
  logic [AW-1:0] m_btag;
  logic [DW-1:0] m_bdata;
  logic [DW-1:0] m_if_last;
  logic [DW-1:0] m_mem_last;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  assign sram_rdata = sram_mem[sram_addr[9:2]];
  always @(posedge clk) if (sram_cs && sram_we) sram_mem[sram_addr[9:2]] <= sram_wdata;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_starve = 0; m_bv = 1'b0; m_btag = '0; m_bdata = '0;
    m_if_last = '0; m_mem_last = '0;
  endtask

  // One granted access: returns ready latency from grant cycle and the data the owner should see.
  task automatic model_access(input bit is_fetch, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input bit other, output int lat,
                              output logic [31:0] data, output int cyc);
    if (is_fetch) begin
      m_starve = 0;
      if (REUSE && m_bv && m_btag == addr) begin
        lat = 1; cyc = 0; data = m_bdata;
      end else begin
        lat = LAT + 1; cyc = LAT; data = ref_mem[addr[9:2]];
        if (REUSE) begin m_bv = 1'b1; m_btag = addr; m_bdata = data; end
      end
      m_if_last = data;
    end else begin
      if (other && m_starve < SMAX) m_starve++;
      lat = LAT + 1; cyc = LAT;
      if (we) begin
        ref_mem[addr[9:2]] = wd;
        if (m_bv && m_btag == addr) m_bv = 1'b0;
        data = m_mem_last;
      end else begin
        data = ref_mem[addr[9:2]];
        m_mem_last = data;
      end
    end
  endtask

  // Both requesters held until served: who goes first and when each ready arrives.
  task automatic model_round(input bit ireq, input logic [31:0] ia, input bit mreq,
                             input logic mwe, input logic [31:0] ma, input logic [31:0] md,
                             output int e_if_k, output int e_mem_k, output int e_cs,
                             output logic [31:0] e_if_d, output logic [31:0] e_mem_d,
                             output logic e_own);
    int l1, l2, c1, c2;
    bit fetch_first;
    e_if_k = 0; e_mem_k = 0; e_cs = 0; l2 = 0; c2 = 0;
    e_if_d = m_if_last; e_mem_d = m_mem_last;
    fetch_first = ireq && (!mreq || m_starve >= SMAX);
    e_own = !fetch_first;
    if (fetch_first) begin
      model_access(1'b1, 1'b0, ia, '0, mreq, l1, e_if_d, c1);
      e_if_k = l1;
      if (mreq) begin
        model_access(1'b0, mwe, ma, md, 1'b0, l2, e_mem_d, c2);
        e_mem_k = l1 + 1 + l2;
      end
    end else begin
      model_access(1'b0, mwe, ma, md, ireq, l1, e_mem_d, c1);
      e_mem_k = l1;
      if (ireq) begin
        model_access(1'b1, 1'b0, ia, '0, 1'b0, l2, e_if_d, c2);
        e_if_k = l1 + 1 + l2;
      end
    end
    e_cs = c1 + c2;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin @(negedge clk); guard++; end
  endtask

  // Drives one round and records what the DUT did; cycle k=1 is the cycle after the grant edge.
  task automatic run_round(input bit ireq, input logic [31:0] ia, input bit mreq, input logic mwe,
                           input logic [31:0] ma, input logic [31:0] md,
                           output int if_k, output int mem_k, output int if_n, output int mem_n,
                           output int cs_n, output int wr_n, output logic [31:0] if_d,
                           output logic [31:0] mem_d, output logic own1, output bit timeout,
                           output logic [2:0] tail);
    if_k = 0; mem_k = 0; if_n = 0; mem_n = 0; cs_n = 0; wr_n = 0;
    if_d = '0; mem_d = '0; own1 = 1'b0;
    wait_idle();
    if_req = ireq; if_addr = ia;
    mem_req = mreq; mem_we = mwe; mem_addr = ma; mem_wdata = md;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) own1 = owner;
      if (sram_cs) cs_n++;
      if (sram_cs && sram_we && sram_addr == ma && sram_wdata == md) wr_n++;
      if (if_ready) begin
        if_n++;
        if (if_k == 0) begin if_k = k; if_d = if_rdata; end
        if_req = 1'b0;
      end
      if (mem_ready) begin
        mem_n++;
        if (mem_k == 0) begin mem_k = k; mem_d = mem_rdata; end
        mem_req = 1'b0; mem_we = 1'b0;
      end
      if ((!ireq || if_k != 0) && (!mreq || mem_k != 0)) break;
    end
    timeout = (ireq && if_k == 0) || (mreq && mem_k == 0);
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    tail = {busy, if_ready, mem_ready};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_cs, sram_we, if_ready, mem_ready, busy, owner} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {sram_cs, sram_we, if_ready, mem_ready, busy, owner});
    end
    checks++;
    if ({sram_addr, sram_wdata, if_rdata, mem_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: addr=%0h wdata=%0h if_rdata=%0h mem_rdata=%0h expected 0",
                         sram_addr, sram_wdata, if_rdata, mem_rdata);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single_fetch();
    int if_k, mem_k, if_n, mem_n, cs_n, wr_n, e_if_k, e_mem_k, e_cs;
    logic [31:0] if_d, mem_d, e_if_d, e_mem_d;
    logic own1, e_own;
    logic [2:0] tail;
    bit to;
    sram_mem[4] = 32'hE3A0_1001; ref_mem[4] = 32'hE3A0_1001;
    model_round(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
    run_round(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
              if_d, mem_d, own1, to, tail);
    checks++; if (to) begin errors++; $display("FAIL single_timeout: no if_ready within budget"); end
    checks++; if (cs_n !== LAT) begin errors++; $display("FAIL single_cs_cycles: got %0d expected %0d", cs_n, LAT); end
    checks++; if (if_k !== e_if_k) begin errors++; $display("FAIL single_latency: got %0d expected %0d", if_k, e_if_k); end
    checks++; if (if_d !== 32'hE3A0_1001) begin errors++; $display("FAIL single_rdata: got %0h expected e3a01001", if_d); end
    checks++; if (if_n !== 1) begin errors++; $display("FAIL single_ready_count: got %0d expected 1", if_n); end
    checks++; if (tail !== 3'b000) begin errors++; $display("FAIL single_tail_busy: got %b expected 000", tail); end
  endtask

  task automatic test_contention();
    int if_k, mem_k, if_n, mem_n, cs_n, wr_n, e_if_k, e_mem_k, e_cs;
    logic [31:0] if_d, mem_d, e_if_d, e_mem_d;
    logic own1, e_own;
    logic [2:0] tail;
    bit to;
    model_round(1'b1, 32'h30, 1'b1, 1'b0, 32'h100, '0, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
    run_round(1'b1, 32'h30, 1'b1, 1'b0, 32'h100, '0, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
              if_d, mem_d, own1, to, tail);
    checks++; if (to) begin errors++; $display("FAIL cont_timeout: if_k=%0d mem_k=%0d", if_k, mem_k); end
    checks++; if (own1 !== 1'b1) begin errors++; $display("FAIL cont_owner: got %b expected 1", own1); end
    checks++; if (mem_k !== e_mem_k) begin errors++; $display("FAIL cont_mem_latency: got %0d expected %0d", mem_k, e_mem_k); end
    checks++; if (if_k - mem_k !== 6) begin errors++; $display("FAIL cont_gap: got %0d expected 6", if_k - mem_k); end
    checks++; if (mem_d !== e_mem_d) begin errors++; $display("FAIL cont_mem_rdata: got %0h expected %0h", mem_d, e_mem_d); end
    checks++; if (if_d !== e_if_d) begin errors++; $display("FAIL cont_if_rdata: got %0h expected %0h", if_d, e_if_d); end
  endtask

  task automatic test_store_load();
    int if_k, mem_k, if_n, mem_n, cs_n, wr_n, e_if_k, e_mem_k, e_cs;
    logic [31:0] if_d, mem_d, e_if_d, e_mem_d;
    logic own1, e_own;
    logic [2:0] tail;
    bit to;
    model_round(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
    run_round(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
              if_d, mem_d, own1, to, tail);
    checks++; if (wr_n !== LAT) begin errors++; $display("FAIL store_we_cycles: got %0d expected %0d", wr_n, LAT); end
    checks++; if (mem_n !== 1 || mem_k !== e_mem_k) begin errors++; $display("FAIL store_ready: count=%0d at=%0d expected 1 at %0d", mem_n, mem_k, e_mem_k); end
    checks++; if (mem_d !== e_mem_d) begin errors++; $display("FAIL store_rdata_hold: got %0h expected %0h", mem_d, e_mem_d); end
    model_round(1'b0, '0, 1'b1, 1'b0, 32'h200, '0, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
    run_round(1'b0, '0, 1'b1, 1'b0, 32'h200, '0, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
              if_d, mem_d, own1, to, tail);
    checks++; if (to) begin errors++; $display("FAIL load_timeout: no mem_ready"); end
    checks++; if (mem_d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_after_store: got %0h expected deadbeef", mem_d); end
  endtask

  task automatic test_starvation();
    for (int pass = 0; pass < 2; pass++) begin
      int nmem, nbefore, if_k, exp_n, e_if_k, lat, cyc;
      bit done;
      logic [31:0] d;
      nmem = 0; nbefore = 0; if_k = 0; exp_n = 0; e_if_k = 0; done = 1'b0;
      while (m_starve < SMAX) begin
        model_access(1'b0, 1'b0, 32'h100, '0, 1'b1, lat, d, cyc);
        exp_n++; e_if_k += lat + 1;
      end
      model_access(1'b1, 1'b0, 32'h80, '0, 1'b1, lat, d, cyc);
      e_if_k += lat;
      model_access(1'b0, 1'b0, 32'h100, '0, 1'b0, lat, d, cyc);
      wait_idle();
      if_req = 1'b1; if_addr = 32'h80; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
      for (int k = 1; k <= 300 && !done; k++) begin
        @(negedge clk);
        if (mem_ready) begin
          nmem++;
          if (if_k != 0) begin mem_req = 1'b0; done = 1'b1; end
        end
        if (if_ready) begin if_k = k; nbefore = nmem; if_req = 1'b0; end
      end
      if_req = 1'b0; mem_req = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL starve_timeout: pass %0d if_k=%0d nmem=%0d", pass, if_k, nmem); end
      checks++; if (nbefore !== exp_n) begin errors++; $display("FAIL starve_grants: pass %0d got %0d expected %0d", pass, nbefore, exp_n); end
      checks++; if (if_k !== e_if_k) begin errors++; $display("FAIL starve_if_time: pass %0d got %0d expected %0d", pass, if_k, e_if_k); end
      if (pass == 1) begin
        checks++; if (nbefore !== SMAX) begin errors++; $display("FAIL starve_cleared: got %0d expected %0d", nbefore, SMAX); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int if_k, mem_k, if_n, mem_n, cs_n, wr_n, e_if_k, e_mem_k, e_cs;
    logic [31:0] if_d, mem_d, e_if_d, e_mem_d;
    logic own1, e_own;
    logic [2:0] tail;
    bit to, seen;
    seen = 1'b0;
    wait_idle();
    if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({sram_cs, sram_we, if_ready, mem_ready, busy, owner} !== 6'b0 ||
        {sram_addr, sram_wdata, if_rdata, mem_rdata} !== '0) begin
      errors++; $display("FAIL midreset_outputs: cs=%b busy=%b addr=%0h if_rdata=%0h expected all 0",
                         sram_cs, busy, sram_addr, if_rdata);
    end
    if_req = 1'b0;
    repeat (4) begin @(negedge clk); if (if_ready || mem_ready || busy || sram_cs) seen = 1'b1; end
    rst = 1'b1;
    model_reset();
    repeat (3) begin @(negedge clk); if (if_ready || mem_ready || busy || sram_cs) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_ready: activity seen=%b expected 0", seen); end
    model_round(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
    run_round(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
              if_d, mem_d, own1, to, tail);
    checks++; if (if_k !== LAT + 1) begin errors++; $display("FAIL midreset_reissue: got %0d expected %0d", if_k, LAT + 1); end
    checks++; if (if_d !== e_if_d) begin errors++; $display("FAIL midreset_rdata: got %0h expected %0h", if_d, e_if_d); end
  endtask

`ifdef FETCH_REUSE_EN
  task automatic test_fetch_reuse();
    int if_k, mem_k, if_n, mem_n, cs_n, wr_n, e_if_k, e_mem_k, e_cs;
    logic [31:0] if_d, mem_d, e_if_d, e_mem_d;
    logic own1, e_own;
    logic [2:0] tail;
    bit to;
    for (int i = 0; i < 2; i++) begin
      model_round(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
      run_round(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
                if_d, mem_d, own1, to, tail);
      checks++; if (if_d !== e_if_d) begin errors++; $display("FAIL reuse_rdata%0d: got %0h expected %0h", i, if_d, e_if_d); end
    end
    checks++; if (if_k !== 1 || cs_n !== 0) begin errors++; $display("FAIL reuse_hit: latency=%0d cs=%0d expected 1 and 0", if_k, cs_n); end
    model_round(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
    run_round(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
              if_d, mem_d, own1, to, tail);
    model_round(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
    run_round(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
              if_d, mem_d, own1, to, tail);
    checks++; if (if_k !== LAT + 1 || cs_n !== LAT) begin errors++; $display("FAIL reuse_invalidate: latency=%0d cs=%0d expected %0d and %0d", if_k, cs_n, LAT + 1, LAT); end
    checks++; if (if_d !== 32'h1234_5678) begin errors++; $display("FAIL reuse_new_data: got %0h expected 12345678", if_d); end
  endtask
`endif

  task automatic test_random(input int rounds);
    int if_k, mem_k, if_n, mem_n, cs_n, wr_n, e_if_k, e_mem_k, e_cs, sel;
    logic [31:0] if_d, mem_d, e_if_d, e_mem_d, ia, ma, md;
    logic own1, e_own, mwe;
    logic [2:0] tail;
    logic [31:0] addrs [4];
    bit to, ireq, mreq;
    addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h100; addrs[3] = 32'h200;
    for (int r = 0; r < rounds; r++) begin
      sel  = $urandom_range(1, 3);
      ireq = sel[0]; mreq = sel[1];
      ia   = addrs[$urandom_range(0, 3)];
      ma   = addrs[$urandom_range(0, 3)];
      md   = $urandom;
      mwe  = mreq && ($urandom_range(0, 1) == 1);
      model_round(ireq, ia, mreq, mwe, ma, md, e_if_k, e_mem_k, e_cs, e_if_d, e_mem_d, e_own);
      run_round(ireq, ia, mreq, mwe, ma, md, if_k, mem_k, if_n, mem_n, cs_n, wr_n,
                if_d, mem_d, own1, to, tail);
      checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: if_k=%0d mem_k=%0d", r, if_k, mem_k); end
      checks++; if (own1 !== e_own) begin errors++; $display("FAIL rnd%0d_owner: got %b expected %b", r, own1, e_own); end
      checks++; if (if_k !== e_if_k || mem_k !== e_mem_k) begin errors++; $display("FAIL rnd%0d_timing: if_k=%0d mem_k=%0d expected %0d %0d", r, if_k, mem_k, e_if_k, e_mem_k); end
      checks++; if (if_n !== int'(ireq) || mem_n !== int'(mreq)) begin errors++; $display("FAIL rnd%0d_ready_count: if=%0d mem=%0d expected %0d %0d", r, if_n, mem_n, ireq, mreq); end
      checks++; if (cs_n !== e_cs) begin errors++; $display("FAIL rnd%0d_cs_cycles: got %0d expected %0d", r, cs_n, e_cs); end
      checks++; if (wr_n !== (mwe ? LAT : 0)) begin errors++; $display("FAIL rnd%0d_write_cycles: got %0d expected %0d", r, wr_n, mwe ? LAT : 0); end
      if (ireq) begin
        checks++; if (if_d !== e_if_d) begin errors++; $display("FAIL rnd%0d_if_rdata: got %0h expected %0h", r, if_d, e_if_d); end
      end
      if (mreq) begin
        checks++; if (mem_d !== e_mem_d) begin errors++; $display("FAIL rnd%0d_mem_rdata: got %0h expected %0h", r, mem_d, e_mem_d); end
      end
      checks++; if (tail !== 3'b000) begin errors++; $display("FAIL rnd%0d_tail: got %b expected 000", r, tail); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    model_reset();
    test_reset();
    test_single_fetch();
    test_contention();
    test_store_load();
    test_starvation();
    test_reset_mid();
`ifdef FETCH_REUSE_EN
    test_fetch_reuse();
`endif
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported, fixed-latency SRAM between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Sequences each access with an FSM, returns read data with a one-cycle ready pulse, and exposes busy/owner so the hazard unit can freeze the pipeline.
- Sits between the fetch stage / memory stage and the SRAM controller pins.

Parameters:
- ADDR_W, 32, byte address width; passed through unmodified.
- DATA_W, 32, data word width.
- SRAM_LAT, 4, cycles sram_cs is held per access (legal range 1..15).
- STARVE_MAX, 8, consecutive memory-stage grants, with if_req pending, before fetch is forced ahead.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse
- mem_req  in  1  memory-stage request; held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- sram_cs  out  1  SRAM select
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data; valid in the last cycle of an access
- busy  out  1  1 in ACCESS or DONE
- owner  out  1  0 = fetch, 1 = memory stage; meaningful while busy

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all outputs are 0; starvation counter is 0.
  - An in-flight access is aborted and no ready pulse is issued for it.
  - Requesters re-present their requests after reset is released.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE; sram_cs=0.
  - Any request: latch the winner's address, write data and we into registers, then go to ACCESS with cnt=0.
- Arbitration when both requests are high:
  - Memory stage wins.
  - Exception: if starve_cnt >= STARVE_MAX, fetch wins.
- ACCESS:
  - sram_cs=1, sram_we = latched we, sram_addr and sram_wdata come from the latch registers.
  - cnt increments each cycle.
  - When cnt == SRAM_LAT-1: register sram_rdata into the owner's rdata register and go to DONE.
- DONE (one cycle):
  - The owner's ready is 1; sram_cs=0.
  - Requests are ignored in this cycle; return to IDLE.
  - A request still high in the following IDLE cycle is treated as a new request.
- Latency: request first sampled in IDLE at edge N → ready high in cycle N+SRAM_LAT+1. Back-to-back throughput is one access per SRAM_LAT+2 cycles.
- Stores: mem_ready pulses in DONE; mem_rdata is don't-care for stores and holds its previous value.
- Starvation counter (width $clog2(STARVE_MAX+1)):
  - Increments on each memory-stage grant while if_req=1, saturating at STARVE_MAX.
  - Clears on each fetch grant.
- rdata registers hold their value until overwritten by the next access of the same owner.
- Inputs that change while the block is busy are ignored; only the values latched in IDLE are used.

Optional Feature:
- Macro: FETCH_REUSE_EN
- Defined: a one-entry fetch buffer (tag, data, valid) is added.
  - On an IDLE fetch grant whose if_addr matches the valid tag: no SRAM access, go straight to DONE, if_ready the next cycle (latency 1), if_rdata = buffered data.
  - Every SRAM fetch fills the buffer.
  - A store whose mem_addr equals the tag clears valid, in the cycle that store is granted.
  - rst clears valid.
- Not defined: every fetch accesses the SRAM; the buffer logic is absent.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, SRAM returns 0xE3A0_1001 → sram_cs high for exactly 4 cycles; if_ready pulses in cycle 5 with if_rdata=0xE3A0_1001; busy falls after DONE.
- if_req and mem_req (load, 0x100) rise in the same cycle → memory stage served first (owner=1); fetch served immediately after; mem_ready precedes if_ready by 6 cycles.
- mem_req held high continuously with back-to-back loads and if_req held high → after 8 memory-stage grants the 9th grant goes to fetch; counter reads 0 afterwards.
- Store mem_we=1, addr 0x200, wdata 0xDEAD_BEEF → sram_we=1 with those values for 4 cycles; mem_ready pulses once; a following load from 0x200 returns 0xDEAD_BEEF.
- rst driven low in ACCESS cycle 2 → all outputs 0 immediately; no ready pulse; after release, a re-issued request completes normally in 5 cycles.
- FETCH_REUSE_EN: fetch 0x40 twice → second if_ready arrives 1 cycle after the request with no sram_cs; a store to 0x40 in between forces the second fetch to take a full SRAM access.
